// File: rtl/rf_dump_if.sv
// Output stream interface of the register-file dump reader: one word plus its
// register index per valid/ready handshake.
interface rf_dump_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          dout_valid;
    logic          dout_ready;
    logic [DW-1:0] dout_data;
    logic [AW-1:0] dout_addr;
    logic          dout_last;

    modport master (
        output dout_valid,
        output dout_data,
        output dout_addr,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  dout_data,
        input  dout_addr,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/rf_dump_reader.sv
// Walks the register file two registers per fetch, streams each word with its
// index and keeps an XOR checksum of every word handed to the consumer.
module rf_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rf_reg1,
    output logic [AW-1:0] rf_reg2,
    input  logic [DW-1:0] rf_read1,
    input  logic [DW-1:0] rf_read2,
    rf_dump_if.master     dout,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND0 = 3'd2,
        ST_SEND1 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 2);

    state_t        state_r, state_nxt_s;
    logic [AW-1:0] idx_r, idx_nxt_s, idx_p1_s;
    logic [DW-1:0] buf0_r, buf1_r;
    logic [DW-1:0] checksum_r, checksum_nxt_s;
    logic          ld_bufs_s;
    logic          is_last_s;

    assign idx_p1_s  = idx_r + AW'(1);
    assign is_last_s = (idx_r == LAST_IDX);
    assign rf_reg1   = idx_r;
    // idx+1 would read 1 during reset; gate it so the read port is quiet.
    assign rf_reg2   = rst_n ? idx_p1_s : {AW{1'b0}};
    assign checksum  = checksum_r;

    // Next-state, index and checksum update; abort overrides every transition.
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        checksum_nxt_s = checksum_r;
        ld_bufs_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    idx_nxt_s      = {AW{1'b0}};
                    checksum_nxt_s = {DW{1'b0}};
                    state_nxt_s    = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    ld_bufs_s   = 1'b1;
                    state_nxt_s = ST_SEND0;
                end
            end
            ST_SEND0: begin
                if (dout.dout_ready) begin
                    checksum_nxt_s = checksum_r ^ buf0_r;
                end else begin
                    checksum_nxt_s = checksum_r;
                end
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (dout.dout_ready) begin
                    state_nxt_s = ST_SEND1;
                end else begin
                    state_nxt_s = ST_SEND0;
                end
            end
            ST_SEND1: begin
                if (dout.dout_ready) begin
                    checksum_nxt_s = checksum_r ^ buf1_r;
                end else begin
                    checksum_nxt_s = checksum_r;
                end
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (dout.dout_ready && is_last_s) begin
                    state_nxt_s = ST_DONE;
                end else if (dout.dout_ready) begin
                    idx_nxt_s   = idx_r + AW'(2);
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_SEND1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, index, fetch buffers and checksum registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= {AW{1'b0}};
            buf0_r     <= {DW{1'b0}};
            buf1_r     <= {DW{1'b0}};
            checksum_r <= {DW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            checksum_r <= checksum_nxt_s;
            if (ld_bufs_s) begin
                buf0_r <= rf_read1;
                buf1_r <= rf_read2;
            end
        end
    end

    // Stream outputs decoded from registered state; held stable during stalls.
    always_comb begin
        dout.dout_valid = 1'b0;
        dout.dout_data  = {DW{1'b0}};
        dout.dout_addr  = {AW{1'b0}};
        dout.dout_last  = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state_r)
            ST_FETCH: begin
                busy = 1'b1;
            end
            ST_SEND0: begin
                busy            = 1'b1;
                dout.dout_valid = 1'b1;
                dout.dout_data  = buf0_r;
                dout.dout_addr  = idx_r;
            end
            ST_SEND1: begin
                busy            = 1'b1;
                dout.dout_valid = 1'b1;
                dout.dout_data  = buf1_r;
                dout.dout_addr  = idx_p1_s;
                dout.dout_last  = is_last_s;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed and randomized bench for rf_dump_reader: a 32-register and an
// 8-register instance, each fed by a behavioural register file.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic [4:0]  reg1_a, reg2_a, reg1_b, reg2_b;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] cs_a, cs_b;

    logic [31:0] rf_a [32];
    logic [31:0] rf_b [32];
    logic [31:0] exp_mem [32];
    logic [31:0] cs_exp;
    int          exp_idx;
    int          checks   = 0;
    int          failures = 0;

    rf_dump_if #(.AW(5), .DW(32)) ifa ();
    rf_dump_if #(.AW(5), .DW(32)) ifb ();

    assign rd1_a = rf_a[reg1_a];
    assign rd2_a = rf_a[reg2_a];
    assign rd1_b = rf_b[reg1_b];
    assign rd2_b = rf_b[reg2_b];

    rf_dump_reader #(.NUM_REGS(32), .AW(5), .DW(32)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .rf_reg1(reg1_a), .rf_reg2(reg2_a), .rf_read1(rd1_a), .rf_read2(rd2_a),
        .dout(ifa.master), .busy(busy_a), .done(done_a), .checksum(cs_a)
    );

    rf_dump_reader #(.NUM_REGS(8), .AW(5), .DW(32)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .rf_reg1(reg1_b), .rf_reg2(reg2_b), .rf_read1(rd1_b), .rf_read2(rd2_b),
        .dout(ifb.master), .busy(busy_b), .done(done_b), .checksum(cs_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
        end
    endtask

    // Reference stream model: word i of a dump is exp_mem[i]; checksum is XOR of accepted words.
    task automatic obs(input string t, input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic l, input logic [31:0] cs, input int n, input logic rdy);
        chk({t, "_checksum"}, cs, cs_exp);
        if (v && exp_idx < n) begin
            chk({t, "_addr"}, {27'd0, a}, exp_idx);
            chk({t, "_data"}, d, exp_mem[exp_idx]);
            chk({t, "_last"}, {31'd0, l}, {31'd0, (exp_idx == n - 1)});
        end
        if (v && rdy && exp_idx < n) begin
            cs_exp = cs_exp ^ exp_mem[exp_idx];
            exp_idx++;
        end
    endtask

    // mode 0 plain, 1 stall at addr 7, 2 start pulse + writes, 3 random ready, 4 abort at addr 10
    task automatic run_a(input int mode, output int last_cyc);
        int   cyc;
        int   stall;
        logic r;
        exp_mem  = rf_a;
        exp_idx  = 0;
        cs_exp   = 32'd0;
        cyc      = 1;
        stall    = 0;
        last_cyc = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("fetch_busy", {31'd0, busy_a}, 32'd1);
        chk("fetch_valid", {31'd0, ifa.dout_valid}, 32'd0);
        while (exp_idx < 32 && cyc < 400) begin
            r = 1'b1;
            if (mode == 1 && ifa.dout_valid && exp_idx == 7 && stall < 5) begin
                r = 1'b0;
                stall++;
            end
            if (mode == 3) r = 1'($urandom_range(0, 1));
            start_a = (mode == 2 && cyc == 10);
            if (mode == 2 && cyc == 5) begin
                rf_a[20]    = 32'hDEADBEEF;
                exp_mem[20] = 32'hDEADBEEF;
            end
            if (mode == 2 && ifa.dout_valid && exp_idx == 20) rf_a[21] = 32'h12345678;
            if (mode == 4 && ifa.dout_valid && exp_idx == 10) begin
                r       = 1'b0;
                abort_a = 1'b1;
            end
            ifa.dout_ready = r;
            obs("a", ifa.dout_valid, ifa.dout_addr, ifa.dout_data, ifa.dout_last, cs_a, 32, r);
            if (abort_a) break;
            if (exp_idx == 32) last_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        chk("words_a", exp_idx, (mode == 4) ? 32'd10 : 32'd32);
    endtask

    task automatic finish_a();
        chk("done_pulse", {31'd0, done_a}, 32'd1);
        chk("done_checksum", cs_a, cs_exp);
        start_a = 1'b1;
        @(negedge clk);
        chk("start_in_done_ignored", {31'd0, busy_a}, 32'd0);
        chk("done_one_cycle", {31'd0, done_a}, 32'd0);
        chk("checksum_hold", cs_a, cs_exp);
        start_a = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lc;
        int cyc;
        rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        ifa.dout_ready = 1'b0; ifb.dout_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rf_a[k] = 32'd1 << k;
            rf_b[k] = (k < 8) ? 32'(k + 1) : 32'd0;
        end
        #1;
        chk("rst_reg2", {27'd0, reg2_a}, 32'd0);
        chk("rst_valid", {31'd0, ifa.dout_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_checksum", cs_a, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_reg1", {27'd0, reg1_a}, 32'd0);
        chk("idle_reg2", {27'd0, reg2_a}, 32'd1);

        // Full dump, ready high: done 49 cycles after start, checksum all ones
        run_a(0, lc);
        chk("last_handshake_cycle", lc, 32'd48);
        chk("checksum_full", cs_exp, 32'hFFFFFFFF);
        finish_a();

        // Stall 5 cycles on addr 7
        run_a(1, lc);
        finish_a();

        // Ignored start mid-dump, write before and after fetch
        run_a(2, lc);
        finish_a();
        for (int k = 0; k < 32; k++) rf_a[k] = 32'd1 << k;

        // Random data and random ready
        for (int k = 0; k < 32; k++) rf_a[k] = $urandom;
        run_a(3, lc);
        finish_a();
        for (int k = 0; k < 32; k++) rf_a[k] = 32'd1 << k;

        // Abort at addr 10 with ready low, then restart from 0
        run_a(4, lc);
        @(negedge clk);
        abort_a = 1'b0;
        chk("abort_valid", {31'd0, ifa.dout_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_no_done", {31'd0, done_a}, 32'd0);
        chk("abort_checksum", cs_a, 32'h000003FF);
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle_done", {31'd0, done_a}, 32'd0);
        end
        run_a(0, lc);
        finish_a();

        // Asynchronous reset while in SEND1
        exp_mem = rf_a; exp_idx = 0; cs_exp = 32'd0; cyc = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        ifa.dout_ready = 1'b1;
        while (!(ifa.dout_valid && ifa.dout_addr == 5'd5) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_send1", {27'd0, ifa.dout_addr}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_reg1", {27'd0, reg1_a}, 32'd0);
        chk("arst_reg2", {27'd0, reg2_a}, 32'd0);
        chk("arst_valid", {31'd0, ifa.dout_valid}, 32'd0);
        chk("arst_data", ifa.dout_data, 32'd0);
        chk("arst_addr", {27'd0, ifa.dout_addr}, 32'd0);
        chk("arst_last", {31'd0, ifa.dout_last}, 32'd0);
        chk("arst_busy", {31'd0, busy_a}, 32'd0);
        chk("arst_done", {31'd0, done_a}, 32'd0);
        chk("arst_checksum", cs_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", {30'd0, busy_a, ifa.dout_valid}, 32'd0);
        end

        // 8-register instance, reg k = k+1, random ready
        for (int k = 0; k < 32; k++) exp_mem[k] = rf_b[k];
        exp_idx = 0; cs_exp = 32'd0; cyc = 0;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        while (exp_idx < 8 && cyc < 200) begin
            logic r;
            r = 1'($urandom_range(0, 1));
            ifb.dout_ready = r;
            obs("b", ifb.dout_valid, ifb.dout_addr, ifb.dout_data, ifb.dout_last, cs_b, 8, r);
            @(negedge clk);
            cyc++;
        end
        chk("words_b", exp_idx, 32'd8);
        chk("done_b", {31'd0, done_b}, 32'd1);
        chk("checksum_b", cs_b, 32'h00000008);
        @(negedge clk);
        chk("idle_b", {31'd0, busy_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
